// File: rtl/block_memory.sv
// block_memory: fixed-latency 128-bit line memory responder, one transaction outstanding.
// Optional BLOCK_MEMORY_WORD_MASK_EN adds a per-word write mask port req_wmask.
module block_memory #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [127:0]      req_wdata,
`ifdef BLOCK_MEMORY_WORD_MASK_EN
  input  logic [3:0]        req_wmask,
`endif
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [127:0]      resp_rdata
);
  localparam int LW    = ADDR_W - 4;
  localparam int LINES = 1 << LW;
  localparam int CW    = $clog2(LATENCY + 1);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t          state;
  logic [CW-1:0]   cnt;
  logic [LW-1:0]   line_q;
  logic            write_q;
  logic [127:0]    wdata_q;
  logic [127:0]    rd_line;
  logic [127:0]    merged;
  logic [3:0]      mask_in;
  logic [3:0]      mask_q;
  logic [127:0]    mem_rd [LINES];
  logic            access;
  logic            unused;
`ifdef BLOCK_MEMORY_WORD_MASK_EN
  assign mask_in = req_wmask;
`else
  assign mask_in = 4'hf;
`endif
  assign unused    = ^req_addr[3:0];
  assign req_ready = state == IDLE;
  assign access    = state == BUSY && cnt == '0;
  assign rd_line   = mem_rd[line_q];
  always_comb begin
    merged = rd_line;
    for (int k = 0; k < 4; k++)
      merged[32*k +: 32] = mask_q[k] ? wdata_q[32*k +: 32] : rd_line[32*k +: 32];
  end
  // Array lines power up holding their own word indices and are never reset.
  for (genvar i = 0; i < LINES; i++) begin : g_line
    logic [127:0] d = {32'(4*i+3), 32'(4*i+2), 32'(4*i+1), 32'(4*i)};
    always_ff @(posedge clk)
      if (access && write_q && line_q == LW'(i)) d <= merged;
    assign mem_rd[i] = d;
  end
  always_ff @(posedge clk)
    if (req_valid && req_ready) begin
      line_q  <= req_addr[ADDR_W-1:4];
      write_q <= req_write;
      wdata_q <= req_wdata;
      mask_q  <= mask_in;
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
    end else
      case (state)
        IDLE: if (req_valid) begin
          state <= BUSY;
          cnt   <= CW'(LATENCY - 1);
        end
        BUSY: if (cnt != '0) cnt <= cnt - CW'(1);
        else begin
          resp_rdata <= write_q ? merged : rd_line;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: if (resp_ready) begin
          resp_valid <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_block_memory.sv
// tb_block_memory: randomized scoreboard bench for block_memory against a word-array reference model.
module tb_block_memory;
  localparam int LAT = 4;
  logic clk = 0, reset = 1, req_valid = 0, req_write = 0, resp_ready = 0;
  logic req_ready, resp_valid;
  logic [9:0] req_addr = '0;
  logic [127:0] req_wdata = '0, resp_rdata;
`ifdef BLOCK_MEMORY_WORD_MASK_EN
  logic [3:0] req_wmask = '0;
`endif
  typedef struct {logic wr; int line; logic [127:0] wd; logic [3:0] m; int acc;} txn_t;
  txn_t q[$];
  txn_t mt;
  logic [31:0] mdl [256];
  int vec = 0, errs = 0, cyc = 0, last_acc = 0, prev_acc = 0;
  bit busy = 0, pv = 0, rnd = 0;
  logic [127:0] held = '0, last_rdata = '0;

  block_memory #(.ADDR_W(10), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef BLOCK_MEMORY_WORD_MASK_EN
    .req_wmask(req_wmask),
`endif
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (!reset && resp_valid && resp_ready) busy = 0;
  always begin
    @(posedge clk);
    #1;
    if (rnd) resp_ready = 1'($urandom_range(0, 1));
  end

  task automatic chk(string n, logic [127:0] a, logic [127:0] e);
    vec++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  // Reference: a flat array of 32-bit words; writes replace the masked words of the line.
  function automatic logic [127:0] apply(txn_t t);
    for (int k = 0; k < 4; k++)
      if (t.wr && t.m[k]) mdl[4*t.line+k] = t.wd[32*k +: 32];
    return {mdl[4*t.line+3], mdl[4*t.line+2], mdl[4*t.line+1], mdl[4*t.line]};
  endfunction

  always @(negedge clk)
    if (reset) pv = 0;
    else begin
      if (resp_valid && !pv) begin
        if (q.size() == 0) begin
          vec++;
          errs++;
          $display("FAIL spurious_resp: got resp_valid=1 expected no response pending");
        end else begin
          mt = q.pop_front();
          held = apply(mt);
          last_rdata = resp_rdata;
          chk("rdata", resp_rdata, held);
          chk("latency", 128'(cyc - mt.acc), 128'(LAT));
        end
      end else if (resp_valid) chk("rdata_hold", resp_rdata, held);
      if (busy) chk("req_ready_busy", 128'(req_ready), 128'(0));
      pv = resp_valid;
    end

  task automatic wait_idle();
    for (int n = 0; n < 200 && busy; n++) begin
      @(posedge clk);
      #1;
    end
    if (busy) begin
      vec++;
      errs++;
      $display("FAIL idle_timeout: got busy=1 expected idle within 200 cycles");
      busy = 0;
      q.delete();
    end
  endtask

  task automatic issue(logic wr, logic [9:0] a, logic [127:0] d, logic [3:0] m);
    wait_idle();
    chk("req_ready_idle", 128'(req_ready), 128'(1));
    req_valid = 1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
`ifdef BLOCK_MEMORY_WORD_MASK_EN
    req_wmask = m;
`else
    m = 4'hf;
`endif
    @(posedge clk);
    #1;
    last_acc = cyc;
    q.push_back('{wr, int'(a[9:4]), d, m, cyc});
    busy = 1;
    req_valid = 0;
    req_write = 1'($urandom);
    req_addr  = 10'($urandom);
    req_wdata = {$urandom, $urandom, $urandom, $urandom};
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mdl[i] = 32'(i);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 128'(resp_valid), 128'(0));
    chk("reset_rdata", resp_rdata, 128'(0));
    reset = 0;
    @(posedge clk);
    #1;
    resp_ready = 1;
    issue(0, 10'h010, '0, 4'hf);
    wait_idle();
    chk("t1_read", last_rdata, {32'd7, 32'd6, 32'd5, 32'd4});
    issue(1, 10'h3F4, {32'hD, 32'hC, 32'hB, 32'hA}, 4'hf);
    issue(0, 10'h3F0, '0, 4'hf);
    wait_idle();
    chk("t2_wr_rd", last_rdata, {32'hD, 32'hC, 32'hB, 32'hA});
    resp_ready = 0;
    issue(0, 10'h040, '0, 4'hf);
    for (int n = 0; n < 50 && !resp_valid; n++) begin
      @(posedge clk);
      #1;
    end
    repeat (5) @(posedge clk);
    #1;
    chk("t3_valid_stall", 128'(resp_valid), 128'(1));
    chk("t3_ready_stall", 128'(req_ready), 128'(0));
    resp_ready = 1;
    @(posedge clk);
    #1;
    chk("t3_valid_after", 128'(resp_valid), 128'(0));
    chk("t3_ready_after", 128'(req_ready), 128'(1));
    issue(1, 10'h020, {4{32'hDEADBEEF}}, 4'hf);
    repeat (2) @(posedge clk);
    #1;
    reset = 1;
    #1;
    chk("t4_rst_valid", 128'(resp_valid), 128'(0));
    chk("t4_rst_rdata", resp_rdata, 128'(0));
    @(posedge clk);
    #1;
    q.delete();
    busy = 0;
    reset = 0;
    @(posedge clk);
    #1;
    issue(0, 10'h020, '0, 4'hf);
    wait_idle();
    chk("t4_dropped_wr", last_rdata, {32'd11, 32'd10, 32'd9, 32'd8});
    for (int i = 0; i < 3; i++) begin
      prev_acc = last_acc;
      issue(0, 10'($urandom), '0, 4'hf);
      chk("t5_period", 128'(last_acc - prev_acc), 128'(LAT + 2));
    end
`ifdef BLOCK_MEMORY_WORD_MASK_EN
    issue(1, 10'h000, {4{32'hFFFFFFFF}}, 4'b0101);
    issue(0, 10'h000, '0, 4'h0);
    wait_idle();
    chk("t6_mask", last_rdata, {32'd3, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF});
`endif
    rnd = 1;
    repeat (150)
      issue(1'($urandom), 10'($urandom), {$urandom, $urandom, $urandom, $urandom}, 4'($urandom));
    wait_idle();
    rnd = 0;
    chk("queue_empty", 128'(q.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
